// File: rtl/dm_sba_slave_mem.sv
// System-bus responder for the debug module's SBA master: a small
// byte-enabled register-file memory behind a req/gnt/r_valid handshake
// with programmable grant delay and response latency. Out-of-range
// accesses are answered with an error flag instead of touching memory.
module dm_sba_slave_mem #(
    parameter int unsigned         BusWidth    = 32,
    parameter int unsigned         Depth       = 16,
    parameter logic [BusWidth-1:0] BaseAddr    = '0,
    parameter int unsigned         GntDelay    = 0,
    parameter int unsigned         RespLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_err_o,
    output logic                  busy_o
);

    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);
    localparam int unsigned IdxBits  = $clog2(Depth);
    localparam int unsigned WordW    = BusWidth - OffBits;
    localparam int unsigned MaxCnt   = (GntDelay > RespLatency) ? GntDelay : RespLatency;
    localparam int unsigned CntW     = (MaxCnt < 2) ? 1 : $clog2(MaxCnt);

    localparam logic [CntW-1:0]  GntInit  = CntW'((GntDelay > 0) ? (GntDelay - 1) : 0);
    localparam logic [CntW-1:0]  RespInit = CntW'(RespLatency - 1);
    localparam logic [WordW-1:0] DepthW   = WordW'(Depth);

    typedef enum logic [1:0] {
        Idle,
        GntWait,
        Resp
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 busy_q;
    logic [BusWidth-1:0]  rdata_q;
    logic                 err_q;
    logic [BusWidth-1:0]  mem_q [Depth];

    logic                 gnt;
    logic                 rValid;
    logic [WordW-1:0]     wordOff;
    logic [IdxBits-1:0]   wordIdx;
    logic                 inRange;
    logic                 doWrite;
    logic [BusWidth-1:0]  readWord;

    // Word offset is taken on the word-aligned address bits only; since
    // BaseAddr is aligned this equals (add - BaseAddr) >> OffBits. The
    // full-width compare keeps addresses below the base from wrapping in.
    assign wordOff  = slave_add_i[BusWidth-1:OffBits] - BaseAddr[BusWidth-1:OffBits];
    assign inRange  = (slave_add_i >= BaseAddr) && (wordOff < DepthW);
    assign wordIdx  = wordOff[IdxBits-1:0];
    assign doWrite  = gnt && slave_we_i && inRange;
    assign readWord = mem_q[wordIdx];

    // Handshake sequencing: grant after the programmed delay, then count
    // down the response latency and pulse r_valid for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        rValid  = 1'b0;
        unique case (state_q)
            Idle: begin
                if (slave_req_i) begin
                    if (GntDelay == 0) begin
                        gnt     = 1'b1;
                        state_d = Resp;
                        cnt_d   = RespInit;
                    end else begin
                        state_d = GntWait;
                        cnt_d   = GntInit;
                    end
                end
            end
            GntWait: begin
                if (!slave_req_i) begin
                    state_d = Idle;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = Resp;
                    cnt_d   = RespInit;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            Resp: begin
                if (cnt_q == '0) begin
                    rValid  = 1'b1;
                    state_d = Idle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // State, latency counter and the registered busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != Idle);
        end
    end

    // Memory array: byte-masked writes at the grant edge, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < int'(Depth); w++) begin
                mem_q[w] <= '0;
            end
        end else if (doWrite) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (slave_be_i[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= slave_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response register: read data (or zero for writes and errors) and the
    // error flag are captured at the grant edge and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (gnt) begin
            rdata_q <= (slave_we_i || !inRange) ? '0 : readWord;
            err_q   <= !inRange;
        end
    end

    assign slave_gnt_o     = gnt;
    assign slave_r_valid_o = rValid;
    assign slave_r_rdata_o = rdata_q;
    assign slave_err_o     = rValid & err_q;
    assign busy_o          = busy_q;

endmodule

// File: doc/dm_sba_slave_mem.md
Name: dm_sba_slave_mem

Overview:
- Bus responder (slave) for the debug module's system-bus master protocol: req/add/we/wdata/be in; gnt, r_valid and r_rdata out.
- Backs the bus with a small byte-enabled register-file memory.
- Grant delay and response latency are programmable, so the SBA master FSM (Read/Write -> WaitRead/WaitWrite) can be exercised against realistic timing.
- Used as the system-bus endpoint in debug-module subsystem benches and small SoC shells; flags out-of-range accesses.

Parameters:
- BusWidth, 32, data/address width in bits; legal values 32 or 64.
- Depth, 16, number of BusWidth-wide words; power of two, >=2.
- BaseAddr, 0, byte address of word 0; aligned to BusWidth/8.
- GntDelay, 0, cycles req must be held before gnt asserts (0 = same-cycle grant).
- RespLatency, 1, cycles from the grant edge to the r_valid pulse; >=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- slave_req_i  in  1  request, held by master until granted
- slave_add_i  in  BusWidth  byte address
- slave_we_i  in  1  1=write, 0=read
- slave_wdata_i  in  BusWidth  write data
- slave_be_i  in  BusWidth/8  byte enables (writes only)
- slave_gnt_o  out  1  grant, single-cycle
- slave_r_valid_o  out  1  response valid, single-cycle, issued for reads and writes
- slave_r_rdata_o  out  BusWidth  read data
- slave_err_o  out  1  error, coincident with r_valid
- busy_o  out  1  transaction in flight (state != Idle)

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i, all flops on rising edge.
- Reset values:
  - gnt, r_valid, err, busy = 0.
  - r_rdata = 0.
  - All memory words = 0.
  - State = Idle; counter = 0.
- Concurrency: one outstanding transaction. No gnt is issued while in GntWait or Resp, except the GntWait->Resp grant.
- States: Idle, GntWait, Resp.
- Idle:
  - If req and GntDelay==0: gnt=1 combinationally in the same cycle; access is performed; go to Resp with cnt=RespLatency-1.
  - If req and GntDelay>0: go to GntWait with cnt=GntDelay-1.
- GntWait:
  - If req drops: return to Idle. No gnt, no response.
  - Else if cnt==0: gnt=1; access performed; go to Resp with cnt=RespLatency-1.
  - Else: cnt decrements.
- Resp:
  - If cnt==0: r_valid=1 (and err if flagged) for exactly one cycle; go to Idle.
  - Else: cnt decrements.
  - In Resp, req is ignored. A new req from Idle is accepted the cycle after r_valid.
- Latency:
  - Grant comes GntDelay cycles after req is first seen.
  - r_valid comes RespLatency cycles after the grant cycle. With defaults, gnt is in cycle N and r_valid in cycle N+1.
- Access at the grant edge:
  - Word index = (add - BaseAddr) >> log2(BusWidth/8). Low address bits are ignored.
  - In range iff add >= BaseAddr and index < Depth. Unsigned subtraction; no wrap into range.
  - Write in range: each byte i with be[i]=1 takes wdata byte i. Other bytes are unchanged. be=0 is a legal no-op write.
  - Read in range: the full word (be ignored) is captured into a response register at the grant edge.
  - Out of range: write is dropped; read data = 0; error flag set.
- Response outputs:
  - r_rdata is driven from the response register and holds its value until the next response is loaded.
  - Write responses load r_rdata = 0.
  - err equals the captured error flag only while r_valid=1; 0 otherwise.
- Read-after-write: a read granted after a write's r_valid returns the written data.
- Reset mid-transaction: everything returns to reset values immediately. Memory is cleared and any pending response is discarded.
- busy_o = (state != Idle), registered.

Test Plan:
- Defaults. Write add=0x8, wdata=0xDEADBEEF, be=0xF -> gnt same cycle, r_valid next cycle, err=0. Then read add=0x8 -> r_rdata=0xDEADBEEF one cycle after gnt.
- Byte enables. Write 0xAABBCCDD to 0x4 with be=0xF. Then write 0x11223344 with be=0x5. Read 0x4 -> 0xAA22CC44.
- Latency. GntDelay=2, RespLatency=3; read req held from cycle 0 -> gnt in cycle 2, r_valid in cycle 5, busy_o=1 from cycle 1 through cycle 5.
- Out of range. Depth=16, BaseAddr=0x100. Read 0x140 -> r_valid with err=1, r_rdata=0. Read 0xFC -> err=1. Write 0x140 -> err=1 and no word is modified.
- Req withdrawn. GntDelay=3; req high for 2 cycles then low -> no gnt, no r_valid, state back to Idle. A next req is serviced normally.
- Reset mid-operation. Write 0x5A5A5A5A to 0x0; assert rst_ni low during Resp of a following read -> r_valid never pulses. After reset, reading 0x0 -> 0x00000000.
